// File: rtl/spi_frame_feeder_if.sv
// Handshake bundle between the trace packer, the frame feeder and the SPI slave.
// The master view belongs to the feeder, the slave view to everything around it.
interface spi_frame_feeder_if #(
    parameter int DEPTH_LOG2 = 3
);
    logic [7:0]          in_byte;
    logic                in_valid;
    logic                in_flush;
    logic                word_req;
    logic                frame_reset;
    logic [15:0]         tx_word;
    logic                frame_avail;
    logic [DEPTH_LOG2:0] level;
    logic                full;
    logic [15:0]         ovf_cnt;

    modport master (
        input  in_byte, in_valid, in_flush, word_req, frame_reset,
        output tx_word, frame_avail, level, full, ovf_cnt
    );

    modport slave (
        output in_byte, in_valid, in_flush, word_req, frame_reset,
        input  tx_word, frame_avail, level, full, ovf_cnt
    );
endinterface

// File: rtl/spi_frame_feeder.sv
// Packs trace bytes into 16-bit words, buffers whole committed frames and
// replays them word-by-word to the SPI trace slave.
module spi_frame_feeder #(
    parameter int FRAME_WORDS = 8,
    parameter int DEPTH_LOG2  = 3
) (
    input logic                clk,
    input logic                rst,
    spi_frame_feeder_if.master bus
);
    localparam int SLOTS = 1 << DEPTH_LOG2;
    localparam int WW    = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int AW    = DEPTH_LOG2 + WW;

    localparam logic [WW-1:0]         LAST_WORD  = WW'(FRAME_WORDS - 1);
    localparam logic [WW-1:0]         WORD_ONE   = WW'(1);
    localparam logic [DEPTH_LOG2-1:0] FRAME_ONE  = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   LEVEL_FULL = (DEPTH_LOG2 + 1)'(SLOTS);

    logic [15:0] mem [1 << AW];

    logic                  byte_phase;
    logic [7:0]            low_byte;
    logic [WW-1:0]         wr_word;
    logic [DEPTH_LOG2-1:0] wr_frame;
    logic                  drop;

    logic [WW-1:0]         rd_word;
    logic [DEPTH_LOG2-1:0] rd_frame;

    logic                  byte_in;
    logic                  frame_start;
    logic                  wr_en;
    logic                  commit;
    logic                  release_frame;
    logic [DEPTH_LOG2:0]   level_next;

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        byte_in       = bus.in_valid && !bus.in_flush;
        frame_start   = byte_in && !byte_phase && (wr_word == '0);
        wr_en         = byte_in && byte_phase && !drop;
        commit        = wr_en && (wr_word == LAST_WORD);
        release_frame = bus.word_req && !bus.frame_reset &&
                        (bus.level != '0) && (rd_word == LAST_WORD);
        level_next    = bus.level;
        if (commit && !release_frame) begin
            level_next = bus.level + LEVEL_ONE;
        end else if (!commit && release_frame) begin
            level_next = bus.level - LEVEL_ONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_phase  <= 1'b0;
            low_byte    <= '0;
            wr_word     <= '0;
            wr_frame    <= '0;
            drop        <= 1'b0;
            bus.ovf_cnt <= '0;
        end else if (bus.in_flush) begin
            byte_phase <= 1'b0;
            wr_word    <= '0;
            drop       <= 1'b0;
        end else if (bus.in_valid) begin
            byte_phase <= !byte_phase;
            if (!byte_phase) begin
                low_byte <= bus.in_byte;
                // Space is judged once per frame; a dropped frame stays dropped.
                if (frame_start && bus.full) begin
                    drop <= 1'b1;
                    if (bus.ovf_cnt != 16'hFFFF) begin
                        bus.ovf_cnt <= bus.ovf_cnt + 16'd1;
                    end
                end
            end else if (wr_word == LAST_WORD) begin
                wr_word <= '0;
                drop    <= 1'b0;
                if (!drop) begin
                    wr_frame <= wr_frame + FRAME_ONE;
                end
            end else begin
                wr_word <= wr_word + WORD_ONE;
            end
        end
    end

    // NOTE: the frame RAM has no reset; its contents are never read before
    // being written, and leaving it unreset lets it map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_frame, wr_word}] <= {bus.in_byte, low_byte};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_word         <= '0;
            rd_frame        <= '0;
            bus.level       <= '0;
            bus.full        <= 1'b0;
            bus.frame_avail <= 1'b0;
            bus.tx_word     <= '0;
        end else begin
            if (bus.level != '0) begin
                bus.tx_word <= mem[{rd_frame, rd_word}];
            end
            if (bus.frame_reset) begin
                rd_word <= '0;
            end else if (bus.word_req && (bus.level != '0)) begin
                if (rd_word == LAST_WORD) begin
                    rd_word  <= '0;
                    rd_frame <= rd_frame + FRAME_ONE;
                end else begin
                    rd_word <= rd_word + WORD_ONE;
                end
            end
            bus.level       <= level_next;
            bus.full        <= (level_next == LEVEL_FULL);
            bus.frame_avail <= (level_next != '0);
        end
    end
endmodule

// File: tb/tb_spi_frame_feeder.sv
// Self-checking bench for spi_frame_feeder: directed scenarios plus random
// traffic, all checked against a frame-queue reference model.
module tb_spi_frame_feeder;
    localparam int FRAME_WORDS = 8;
    localparam int DEPTH_LOG2  = 3;
    localparam int SLOTS       = 1 << DEPTH_LOG2;
    localparam int FBYTES      = 2 * FRAME_WORDS;

    typedef logic [FRAME_WORDS*16-1:0] frame_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    spi_frame_feeder_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

    spi_frame_feeder #(
        .FRAME_WORDS(FRAME_WORDS),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    string phase_tag = "init";

    // Reference model: a queue of committed frames and the frame being built.
    frame_t      fq[$];
    frame_t      cur;
    int          nbytes;
    bit          m_drop;
    int          m_rd;
    int          m_ovf;
    logic [15:0] m_tx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        fq.delete();
        cur    = '0;
        nbytes = 0;
        m_drop = 1'b0;
        m_rd   = 0;
        m_ovf  = 0;
        m_tx   = '0;
    endfunction

    function automatic void model_step(input bit v, input logic [7:0] b, input bit fl,
                                       input bit rq, input bit fr);
        int lvl = fq.size();
        if (lvl != 0) m_tx = fq[0][m_rd*16 +: 16];
        if (fr) begin
            m_rd = 0;
        end else if (rq && lvl != 0) begin
            if (m_rd == FRAME_WORDS - 1) begin
                m_rd = 0;
                void'(fq.pop_front());
            end else begin
                m_rd++;
            end
        end
        if (fl) begin
            nbytes = 0;
            m_drop = 1'b0;
            cur    = '0;
        end else if (v) begin
            if (nbytes == 0 && lvl == SLOTS) begin
                m_drop = 1'b1;
                if (m_ovf < 65535) m_ovf++;
            end
            cur[nbytes*8 +: 8] = b;
            nbytes++;
            if (nbytes == FBYTES) begin
                if (!m_drop) fq.push_back(cur);
                nbytes = 0;
                m_drop = 1'b0;
            end
        end
    endfunction

    task automatic compare_all();
        check({phase_tag, ".tx_word"},     32'(bus.tx_word),     32'(m_tx));
        check({phase_tag, ".level"},       32'(bus.level),       fq.size());
        check({phase_tag, ".frame_avail"}, 32'(bus.frame_avail), 32'(fq.size() != 0));
        check({phase_tag, ".full"},        32'(bus.full),        32'(fq.size() == SLOTS));
        check({phase_tag, ".ovf_cnt"},     32'(bus.ovf_cnt),     m_ovf);
    endtask

    task automatic cycle(input bit v, input logic [7:0] b, input bit fl,
                         input bit rq, input bit fr);
        @(negedge clk);
        bus.in_valid    = v;
        bus.in_byte     = b;
        bus.in_flush    = fl;
        bus.word_req    = rq;
        bus.frame_reset = fr;
        @(posedge clk);
        model_step(v, b, fl, rq, fr);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulse_req(input int n);
        repeat (n) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic write_frame_inc(input logic [7:0] base);
        for (int i = 0; i < FBYTES; i++) cycle(1'b1, base + 8'(i), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".tx_word"},     32'(bus.tx_word),     32'h0);
        check({tag, ".level"},       32'(bus.level),       32'h0);
        check({tag, ".frame_avail"}, 32'(bus.frame_avail), 32'h0);
        check({tag, ".full"},        32'(bus.full),        32'h0);
        check({tag, ".ovf_cnt"},     32'(bus.ovf_cnt),     32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst             = 1'b1;
        bus.in_byte     = '0;
        bus.in_valid    = 1'b0;
        bus.in_flush    = 1'b0;
        bus.word_req    = 1'b0;
        bus.frame_reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // First frame 0x00..0x0F, then read it out with spaced requests.
        phase_tag = "first_frame";
        write_frame_inc(8'h00);
        check("first_frame.level_after_commit", 32'(bus.level), 32'd1);
        check("first_frame.avail_after_commit", 32'(bus.frame_avail), 32'd1);
        idle(1);
        for (int k = 0; k < FRAME_WORDS; k++) begin
            check("first_frame.word_seq", 32'(bus.tx_word), {16'h0, 8'(2*k+1), 8'(2*k)});
            pulse_req(1);
            idle(3);
        end
        check("first_frame.level_drained", 32'(bus.level), 32'd0);
        check("first_frame.avail_drained", 32'(bus.frame_avail), 32'd0);

        // Fill every slot, overflow once, free one slot and refill it.
        phase_tag = "overflow";
        for (int f = 0; f < SLOTS; f++) write_frame_inc(8'(16 * (f + 1)));
        check("overflow.full_at_8", 32'(bus.full), 32'd1);
        write_frame_inc(8'h90);
        check("overflow.ovf_cnt", 32'(bus.ovf_cnt), 32'd1);
        check("overflow.level_after_drop", 32'(bus.level), 32'd8);
        pulse_req(FRAME_WORDS);
        write_frame_inc(8'hA0);
        check("overflow.level_refilled", 32'(bus.level), 32'd8);
        pulse_req(FRAME_WORDS * (SLOTS - 1));
        idle(1);
        check("overflow.tenth_frame_head", 32'(bus.tx_word), 32'h0000_A1A0);
        pulse_req(FRAME_WORDS);

        // Rewind a partially read frame, then replay and release it.
        phase_tag = "rewind";
        write_frame_inc(8'h00);
        idle(1);
        pulse_req(3);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        idle(1);
        check("rewind.tx_word0", 32'(bus.tx_word), 32'h0000_0100);
        check("rewind.level_kept", 32'(bus.level), 32'd1);
        pulse_req(FRAME_WORDS);
        check("rewind.level_released", 32'(bus.level), 32'd0);

        // Release of the last word coincides with a new commit.
        phase_tag = "commit_release";
        write_frame_inc(8'h30);
        pulse_req(FRAME_WORDS - 1);
        for (int i = 0; i < FBYTES - 1; i++) cycle(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h4F, 1'b0, 1'b1, 1'b0);
        check("commit_release.level", 32'(bus.level), 32'd1);
        check("commit_release.avail", 32'(bus.frame_avail), 32'd1);
        idle(1);
        check("commit_release.new_head", 32'(bus.tx_word), 32'h0000_4140);
        pulse_req(FRAME_WORDS);

        // A flushed partial frame leaves no trace in the next frame.
        phase_tag = "flush";
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'hE0 + 8'(i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
        write_frame_inc(8'h50);
        check("flush.level", 32'(bus.level), 32'd1);
        idle(1);
        check("flush.tx_word0", 32'(bus.tx_word), 32'h0000_5150);
        pulse_req(FRAME_WORDS);

        // Random traffic, alternating slow and fast readers to reach full.
        phase_tag = "random";
        for (int blk = 0; blk < 6; blk++) begin
            int rq_pct = (blk % 2 == 0) ? 8 : 55;
            for (int c = 0; c < 500; c++) begin
                cycle($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 2,
                      $urandom_range(0, 99) < rq_pct, $urandom_range(0, 99) < 3);
            end
        end

        // Asynchronous reset in the middle of a frame.
        phase_tag = "async_reset";
        write_frame_inc(8'h60);
        for (int i = 0; i < 7; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.word_req = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        write_frame_inc(8'h70);
        idle(1);
        check("async_reset.tx_after", 32'(bus.tx_word), 32'h0000_7170);
        pulse_req(FRAME_WORDS);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_frame_feeder.md
Name: spi_frame_feeder

Overview:
- Upstream of the SPI trace slave. Packs trace bytes into 16-bit words and groups them into frames of FRAME_WORDS words.
- Buffers whole committed frames and presents them word-by-word to the SPI slave.
- Drives transmitIn (frame_avail) and tx_word, and consumes the slave's next-word strobe and frame-reset strobe. Both strobes are already synchronised to clk upstream of this block.
- Single clock domain.

Parameters:
- FRAME_WORDS, 8, 16-bit words per frame. Must equal the SPI slave's data-words-per-frame.
- DEPTH_LOG2, 3, log2 of the number of frame slots in the buffer (default 8 slots).

Ports:
- clk  in  1  master clock.
- rst  in  1  asynchronous, active-high reset.
- in_byte  in  8  trace byte from the packet assembler.
- in_valid  in  1  in_byte valid this cycle.
- in_flush  in  1  discard the partially written frame.
- word_req  in  1  single-cycle pulse (synchronised tx_free): current word consumed, advance to the next.
- frame_reset  in  1  single-cycle pulse (synchronised rxFrameReset): rewind the current read frame.
- tx_word  out  16  current word for the SPI slave. The first byte of a pair is in [7:0], the second in [15:8].
- frame_avail  out  1  at least one committed frame is held (drives transmitIn).
- level  out  DEPTH_LOG2+1  number of committed frames held.
- full  out  1  level == 2^DEPTH_LOG2.
- ovf_cnt  out  16  frames dropped because the buffer was full. Saturates at 0xFFFF.

Behaviour:
- Reset (async assert, sync release): all pointers, byte/word indices and level = 0; tx_word = 0; frame_avail = 0; full = 0; ovf_cnt = 0; drop flag = 0. Memory contents are don't-care.
- Storage is 2^DEPTH_LOG2 × FRAME_WORDS × 16-bit RAM, addressed {frame_ptr, word_idx}.
- Write side:
  - Byte phase toggles on each in_valid.
  - Even byte: held in a low-byte register.
  - Odd byte: word {in_byte, low_byte} written at {wr_frame, wr_word}; wr_word increments.
- Frame start:
  - On the first byte of a frame (wr_word == 0, even phase), if full == 1, the drop flag is set for the whole frame.
  - ovf_cnt increments once, at that byte, saturating.
  - A dropped frame still counts through all 2×FRAME_WORDS bytes but writes nothing.
  - Once the drop flag is set for a frame, the block does not re-evaluate space mid-frame.
- Commit:
  - On the cycle the last word of a non-dropped frame is written, wr_frame increments (wraps modulo 2^DEPTH_LOG2) and level increments.
  - level and frame_avail are visible on the next cycle.
  - Indices then return to 0 and the drop flag clears.
- in_flush: resets byte phase, wr_word and drop flag to 0 without committing. It has priority over an in_valid in the same cycle, and that byte is discarded.
- Read side:
  - tx_word is registered: tx_word <= RAM[{rd_frame, rd_word}] every cycle, so it reflects a pointer change after 1 clk.
  - When level == 0, tx_word holds its value.
- word_req with level != 0:
  - If rd_word < FRAME_WORDS-1, rd_word increments.
  - Otherwise rd_word becomes 0, rd_frame increments (wraps) and level decrements (release).
- word_req with level == 0: ignored.
- frame_reset: rd_word <= 0; the frame is not released. It has priority over a simultaneous word_req.
- Simultaneous commit and release in the same cycle: level is unchanged; pointers move independently.
- No read-during-write hazard exists: only committed frames are read, and a slot being written is never a committed slot.
- frame_avail = (level != 0), registered with level. It must not drop mid-frame except on release of the final word.

Test Plan:
- Write bytes 0x00..0x0F (16 in_valid cycles) → 1 clk after the 16th byte, level = 1, frame_avail = 1; 1 clk later tx_word = 0x0100.
- From that state, issue 8 word_req pulses spaced 4 clk apart → tx_word sequence 0x0100, 0x0302, 0x0504, …, 0x0F0E; after the 8th pulse, level = 0 and frame_avail = 0.
- Commit 8 frames (full = 1), then write a 9th frame → full stays 1, ovf_cnt = 1, level = 8. Release one frame, write a 10th frame with bytes 0xA0..0xAF → accepted, level = 8, and it is read out after frame 8.
- Issue 3 word_req pulses, then frame_reset → tx_word returns to word 0 (0x0100), level unchanged. Then issue 8 word_req pulses → the full frame is replayed and released.
- Hold level = 1 and assert the last word_req in the same cycle as a new frame commit → level remains 1 and frame_avail never deasserts.
- Write 5 bytes, then pulse in_flush, then write 16 fresh bytes → a single frame is committed whose tx_word[0] is built from the fresh bytes. Separately, assert rst mid-frame → all outputs return to reset values immediately (async).
